// File: rtl/hbus_types_pkg.sv
// Shared hbus types: bus width, master FSM states and the read-tag carried
// alongside each read beat while the register block produces its data.
package hbus_types_pkg;

  localparam int IfWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } hbus_mst_state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/hbus_rd_pipe.sv
// Read-tag delay line matching the register block read latency; captures
// hdata_i when a tag falls out and presents it on the rdata stream.
module hbus_rd_pipe #(
  parameter int IfWidth   = hbus_types_pkg::IfWidth,
  parameter int RdLatency = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  hbus_types_pkg::rd_tag_t tag_in,
  input  logic [IfWidth-1:0]     hdata_i,
  output logic                   rdata_valid,
  output logic [IfWidth-1:0]     rdata,
  output logic                   rdata_last
);
  import hbus_types_pkg::*;

  rd_tag_t [RdLatency-1:0] vld_pipe;
  rd_tag_t                 tag_out;

  assign tag_out = vld_pipe[RdLatency-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe    <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
    end else begin
      vld_pipe[0] <= tag_in;
      for (int i = 1; i < RdLatency; i++) vld_pipe[i] <= vld_pipe[i-1];
      rdata_valid <= tag_out.valid;
      rdata_last  <= tag_out.valid & tag_out.last;
      if (tag_out.valid) rdata <= hdata_i;
    end
  end

endmodule

// File: rtl/hbus_master.sv
// hbus initiator: accepts single/incrementing burst commands, drives the
// register bus one beat per cycle and returns read data on a stream.
module hbus_master #(
  parameter int IfWidth   = hbus_types_pkg::IfWidth,
  parameter int LenWidth  = 4,
  parameter int RdLatency = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [IfWidth-1:0]  cmd_addr,
  input  logic [LenWidth-1:0] cmd_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [IfWidth-1:0]  wdata,
  output logic                rdata_valid,
  output logic [IfWidth-1:0]  rdata,
  output logic                rdata_last,
  output logic                busy,
  output logic                hen,
  output logic                hwr_rd,
  output logic [IfWidth-1:0]  haddr,
  output logic [IfWidth-1:0]  hdata_o,
  input  logic [IfWidth-1:0]  hdata_i
);
  import hbus_types_pkg::*;

  hbus_mst_state_e     state_q, state_d;
  logic [IfWidth-1:0]  addr_q;
  logic [LenWidth-1:0] len_q, cnt_q;
  logic                wr_q, rd_last_q;
  logic                cmd_hs, beat_go, last_beat;
  rd_tag_t             tag_in;

  assign cmd_hs      = (state_q == IDLE) && cmd_valid && cmd_ready;
  assign wdata_ready = (state_q == WRITE);
  assign last_beat   = (cnt_q == len_q);
  assign beat_go     = (state_q == READ) || ((state_q == WRITE) && wdata_valid);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_hs) state_d = cmd_wr ? WRITE : READ;
      WRITE: if (wdata_valid && last_beat) state_d = DRAIN;
      READ:  if (last_beat) state_d = DRAIN;
      // writes leave after their final bus cycle; reads wait for the last rdata
      DRAIN: if (wr_q || (rdata_valid && rdata_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      rd_last_q <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      hen       <= 1'b0;
      hwr_rd    <= 1'b0;
      haddr     <= '0;
      hdata_o   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      hen       <= beat_go;
      rd_last_q <= (state_q == READ) && last_beat;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        wr_q   <= cmd_wr;
        cnt_q  <= '0;
      end else if (beat_go) begin
        hwr_rd <= (state_q == WRITE);
        haddr  <= addr_q;
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
        if (state_q == WRITE) hdata_o <= wdata;
      end
    end
  end

  // tag rides with the registered bus beat so the pipe depth equals the read latency
  assign tag_in.valid = hen & ~hwr_rd;
  assign tag_in.last  = rd_last_q;

  hbus_rd_pipe #(
    .IfWidth  (IfWidth),
    .RdLatency(RdLatency)
  ) u_rd_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .tag_in     (tag_in),
    .hdata_i    (hdata_i),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last)
  );

endmodule

// File: tb/tb_hbus_master.sv
// Directed bench for hbus_master with a latency-1 register responder that
// returns haddr^0xFF; bus and rdata activity is logged at the falling edge.
module tb_hbus_master;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_last, busy;
  logic [7:0] rdata;
  logic       hen, hwr_rd;
  logic [7:0] haddr, hdata_o, hdata_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {int cyc; logic wr; logic [7:0] addr; logic [7:0] data;} beat_t;
  typedef struct {int cyc; logic [7:0] d; logic last;} rd_t;
  typedef struct {int cyc; logic busy;} hs_t;

  beat_t bus_q[$];
  rd_t   rd_q[$];
  int    wd_q[$];
  hs_t   hs_q[$];
  int    ready_busy_viol = 0;

  hbus_master dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .busy(busy), .hen(hen), .hwr_rd(hwr_rd), .haddr(haddr),
    .hdata_o(hdata_o), .hdata_i(hdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    hdata_i <= (hen && !hwr_rd) ? (haddr ^ 8'hFF) : 8'h00;
  end

  always @(negedge clk) begin
    if (hen) bus_q.push_back('{cyc, hwr_rd, haddr, hdata_o});
    if (rdata_valid) rd_q.push_back('{cyc, rdata, rdata_last});
    if (wdata_valid && wdata_ready) wd_q.push_back(cyc);
    if (cmd_valid && cmd_ready) hs_q.push_back('{cyc, busy});
    if (busy && cmd_ready) ready_busy_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    bus_q.delete(); rd_q.delete(); wd_q.delete(); hs_q.delete();
    ready_busy_viol = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || !cmd_ready) && n < 200) begin tick(); n++; end
    if (n >= 200) chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  // present a command and hold it until the cycle it is accepted
  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [3:0] l);
    logic acc;
    int n = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    do begin acc = cmd_ready; tick(); n++; end while (!acc && n < 200);
    if (!acc) chk("cmd_accept_timeout", acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] l,
                          input int stall_after, input int stall_n);
    send_cmd(1'b1, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      wdata_valid = 1'b1; wdata = 8'(b + 1);
      if (l == 0) wdata = 8'hA5;
      tick();
      wdata_valid = 1'b0;
      if (b == stall_after) repeat (stall_n) tick();
    end
    wait_idle("write");
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] l, input string tag);
    clear_logs();
    send_cmd(1'b0, a, l);
    wait_idle(tag);
    chk({tag, "_nbeats"}, bus_q.size(), int'(l) + 1);
    chk({tag, "_nrdata"}, rd_q.size(), int'(l) + 1);
    if (bus_q.size() == int'(l) + 1 && rd_q.size() == int'(l) + 1) begin
      for (int i = 0; i <= int'(l); i++) begin
        chk($sformatf("%s_addr%0d", tag, i), bus_q[i].addr, 8'(a + i));
        chk($sformatf("%s_wr%0d", tag, i), bus_q[i].wr, 0);
        chk($sformatf("%s_bcyc%0d", tag, i), bus_q[i].cyc, bus_q[0].cyc + i);
        chk($sformatf("%s_rd%0d", tag, i), rd_q[i].d, 8'(a + i) ^ 8'hFF);
        chk($sformatf("%s_last%0d", tag, i), rd_q[i].last, (i == int'(l)));
      end
      chk({tag, "_lat"}, rd_q[0].cyc, bus_q[0].cyc + 2);
    end
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    tick(); tick();
    chk("rst_hen", hen, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    rstn = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // single write
    clear_logs();
    do_write(8'h10, 4'd0, -1, 0);
    chk("sw_nbeats", bus_q.size(), 1);
    if (bus_q.size() == 1 && wd_q.size() == 1) begin
      chk("sw_wr", bus_q[0].wr, 1);
      chk("sw_addr", bus_q[0].addr, 8'h10);
      chk("sw_data", bus_q[0].data, 8'hA5);
      chk("sw_lat", bus_q[0].cyc, wd_q[0] + 1);
    end
    chk("sw_busy_done", busy, 0);

    // write burst with a two-cycle stall after beat 2
    clear_logs();
    do_write(8'h20, 4'd3, 1, 2);
    chk("wb_nbeats", bus_q.size(), 4);
    if (bus_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wb_addr%0d", i), bus_q[i].addr, 8'h20 + 8'(i));
        chk($sformatf("wb_data%0d", i), bus_q[i].data, 8'(i + 1));
        chk($sformatf("wb_wr%0d", i), bus_q[i].wr, 1);
      end
      chk("wb_gap", bus_q[2].cyc - bus_q[1].cyc, 3);
      chk("wb_b2b", bus_q[1].cyc - bus_q[0].cyc, 1);
    end

    do_read(8'h30, 4'd3, "rb");
    do_read(8'hFE, 4'd2, "wrap");

    // reset during the second beat of an 8-beat read
    clear_logs();
    send_cmd(1'b0, 8'h60, 4'd7);
    begin
      int n = 0;
      while (!(hen && haddr == 8'h61) && n < 50) begin tick(); n++; end
      chk("mr_beat2_seen", haddr, 8'h61);
    end
    rstn = 1'b0;
    tick();
    chk("mr_hen", hen, 0);
    chk("mr_hwr_rd", hwr_rd, 0);
    chk("mr_haddr", haddr, 0);
    chk("mr_hdata_o", hdata_o, 0);
    chk("mr_cmd_ready", cmd_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rdata", {rdata_valid, rdata_last, rdata}, 0);
    rstn = 1'b1;
    rd_q.delete();
    repeat (6) tick();
    chk("mr_no_rdata", rd_q.size(), 0);
    chk("mr_cmd_ready_back", cmd_ready, 1);
    do_read(8'h70, 4'd0, "mr_fresh");

    // back-to-back: second command held valid while the first runs
    clear_logs();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h40; cmd_len = 4'd1;
    begin
      logic acc;
      do begin acc = cmd_ready; tick(); end while (!acc);
    end
    cmd_addr = 8'h50; cmd_len = 4'd0;
    begin
      logic acc;
      int n = 0;
      do begin acc = cmd_ready; tick(); n++; end while (!acc && n < 100);
      chk("bb_second_accepted", acc, 1);
    end
    cmd_valid = 1'b0;
    wait_idle("bb");
    chk("bb_nhs", hs_q.size(), 2);
    chk("bb_nrdata", rd_q.size(), 3);
    if (hs_q.size() == 2 && rd_q.size() == 3) begin
      chk("bb_hs2_busy", hs_q[1].busy, 0);
      chk("bb_hs2_after_drain", hs_q[1].cyc > rd_q[1].cyc, 1);
      chk("bb_rd2_data", rd_q[2].d, 8'hAF);
    end
    chk("bb_ready_while_busy", ready_busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hbus_master.md
Name: hbus_master

Overview:
- Initiator end of the hbus register bus. It drives hen, hwr_rd, haddr and the write data that the register block receives.
- Accepts a command (single or incrementing burst) on a valid/ready interface and streams write data in.
- Returns read data on an output stream.
- Sits between a test/CPU-side agent and the mreg_burst register block.

Parameters:
- IfWidth, hbus_types_pkg::IfWidth (8): address/data width.
- LenWidth, 4: burst length field width; beats = cmd_len+1, maximum 16.
- RdLatency, 1: cycles from a read address beat to valid hdata from the register block. Legal range 1..4.

Ports:
- clk  in  1  bus clock
- rstn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  IfWidth  start address
- cmd_len  in  LenWidth  beats minus one
- wdata_valid  in  1  write data present
- wdata_ready  out  1  write data accepted this cycle
- wdata  in  IfWidth  write data
- rdata_valid  out  1  read data strobe; no backpressure
- rdata  out  IfWidth  read data
- rdata_last  out  1  marks last read beat of burst
- busy  out  1  burst in progress or read pipeline not empty
- hen  out  1  bus enable
- hwr_rd  out  1  1=write, 0=read
- haddr  out  IfWidth  bus address
- hdata_o  out  IfWidth  write data; the bus wrapper drives hdata with it only while hen&hwr_rd
- hdata_i  in  IfWidth  bus data sampled on reads

Behaviour:
- All outputs are registered. Reset (rstn=0 at posedge) forces:
  - hen=0, hwr_rd=0, haddr=0, hdata_o=0
  - cmd_ready=0, wdata_ready=0
  - rdata_valid=0, rdata=0, rdata_last=0, busy=0
  - state=IDLE, beat counter cleared, read pipeline cleared
- Reset mid-burst aborts the burst silently. Nothing is replayed, and no rdata is produced for beats in flight.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch addr, len and wr; beat counter = 0; go to WRITE if cmd_wr, else READ. cmd_ready drops the next cycle.
  - hen=0.
- WRITE:
  - wdata_ready=1 combinationally.
  - On each wdata_valid&wdata_ready, the next cycle drives hen=1, hwr_rd=1, haddr=cur_addr, hdata_o=wdata. cur_addr then increments.
  - If wdata_valid=0, the next cycle has hen=0 (bubble) and haddr/hdata_o hold.
  - After beat cmd_len is accepted, wdata_ready drops; the FSM returns to IDLE after that beat's bus cycle.
  - Write latency: 1 cycle from wdata handshake to bus beat.
- READ:
  - Issues one beat per cycle back-to-back: hen=1, hwr_rd=0, haddr=cur_addr. cur_addr then increments.
  - Each beat pushes a tag (valid, last) into a RdLatency-deep shift pipeline.
  - After the last beat, go to DRAIN with hen=0.
- Read capture:
  - When a tag exits the pipeline, hdata_i is sampled that cycle.
  - The next cycle sets rdata_valid=1, rdata=captured data, rdata_last=tag.last.
  - Total: a beat issued at cycle N gives rdata_valid at cycle N+RdLatency+1.
- DRAIN: wait until the pipeline is empty and the final rdata has been emitted, then go to IDLE.
- busy=1 in any state other than IDLE. It also stays 1 while any pipeline tag remains.
- Address arithmetic: IfWidth-bit increment, wrapping modulo 2^IfWidth (0xFF -> 0x00). No error is raised on wrap.
- hwr_rd holds its last value when hen=0. It is only meaningful when hen=1.
- A new command is not accepted until the state is IDLE, so commands and beats never overlap.
- cmd_len=0 is a single access.

Decomposition:
- hbus_types_pkg additions:
  - IfWidth (reused)
  - enum hbus_mst_state_e {IDLE, WRITE, READ, DRAIN}
  - typedef struct rd_tag_t {valid, last}
- One sub-module: hbus_rd_pipe. It is a RdLatency-deep tag shift register and captures hdata_i into the rdata registers.

Test Plan:
- Single write: cmd_wr=1, addr=0x10, len=0, wdata=0xA5 -> exactly one cycle with hen=1, hwr_rd=1, haddr=0x10, hdata_o=0xA5, one cycle after the handshake. busy returns to 0.
- Write burst with stall:
  - Stimulus: addr=0x20, len=3, data 0x01..0x04, wdata_valid low for 2 cycles after beat 2.
  - Response: beats at haddr 0x20..0x23 with matching data, and 2 hen=0 cycles between beats 2 and 3.
- Read burst:
  - Stimulus: addr=0x30, len=3, RdLatency=1, responder returning addr^0xFF.
  - Response: 4 consecutive hen=1, hwr_rd=0 cycles; rdata 0xCF, 0xCE, 0xCD, 0xCC; rdata_last only on 0xCC; first rdata 2 cycles after the first beat.
- Address wrap: read addr=0xFE, len=2 -> haddr sequence 0xFE, 0xFF, 0x00.
- Reset mid-read:
  - Stimulus: rstn=0 during beat 2 of a len=7 read.
  - Response: next cycle all outputs are 0 and state is IDLE, with no further rdata_valid. After rstn=1, cmd_ready=1 and a fresh single read completes correctly.
- Back-to-back commands: cmd_valid held high with a second command queued -> it is not accepted until busy=0. cmd_ready=0 throughout the first burst and the drain.
